// File: rtl/wb_fifo_drain_ctrl.sv
// ============================================================================
// Module   : wb_fifo_drain_ctrl
// Brief    : Wishbone sequencer that polls a FIFO word count, bursts single
//            word reads and forwards each word on a valid/ready stream.
//            Optional watchdog: define DRAIN_CTRL_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo_drain_ctrl #(
    parameter int ADR_W     = 4,
    parameter int BURST_MAX = 8,
    parameter int POLL_GAP  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    input  logic        wbs_ack_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbd_cyc_o,
    output logic        wbd_stb_o,
    input  logic        wbd_ack_i,
    input  logic [31:0] wbd_dat_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [31:0] m_data_o,
    output logic        busy_o,
    output logic [15:0] word_cnt_o,
    output logic        err_o
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_POLL = 3'd1;
    localparam logic [2:0] c_GAP  = 3'd2;
    localparam logic [2:0] c_READ = 3'd3;
    localparam logic [2:0] c_PUSH = 3'd4;

    localparam int c_CNT_W = ADR_W + 1;
    localparam int c_GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [c_CNT_W-1:0] c_BURST    = c_CNT_W'(BURST_MAX);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(POLL_GAP - 1);

    logic [2:0]         r_state;
    logic               r_wbs_stb;
    logic               r_wbd_stb;
    logic               r_valid;
    logic [31:0]        r_data;
    logic [c_CNT_W-1:0] r_rem;
    logic [c_GAP_W-1:0] r_gap;
    logic [15:0]        r_word_cnt;

    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_clamp;
    logic               w_timeout;
    logic               w_status_unused;

    assign w_count         = wbs_dat_i[c_CNT_W-1:0];
    assign w_clamp         = (w_count > c_BURST) ? c_BURST : w_count;
    assign w_status_unused = ^wbs_dat_i[31:c_CNT_W];

`ifdef DRAIN_CTRL_WATCHDOG_EN
    logic [7:0] r_wdog;
    logic       r_err;
    logic       w_stb_any;
    logic       w_ack_any;

    assign w_stb_any = r_wbs_stb | r_wbd_stb;
    assign w_ack_any = (r_wbs_stb & wbs_ack_i) | (r_wbd_stb & wbd_ack_i);
    // Fires on the 255th consecutive strobe cycle without an ack.
    assign w_timeout = w_stb_any && !w_ack_any && (r_wdog == 8'd254);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            if (!w_stb_any || w_ack_any || w_timeout) begin
                r_wdog <= 8'd0;
            end else begin
                r_wdog <= r_wdog + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_wbs_stb  <= 1'b0;
            r_wbd_stb  <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 32'd0;
            r_rem      <= '0;
            r_gap      <= '0;
            r_word_cnt <= 16'd0;
        end else if (w_timeout) begin
            r_wbs_stb <= 1'b0;
            r_wbd_stb <= 1'b0;
            r_rem     <= '0;
            r_state   <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (en_i) begin
                        r_state <= c_POLL;
                    end
                end
                c_POLL: begin
                    // Strobe rises one edge after entry and drops on the ack edge.
                    if (!r_wbs_stb) begin
                        r_wbs_stb <= 1'b1;
                    end else if (wbs_ack_i) begin
                        r_wbs_stb <= 1'b0;
                        r_rem     <= w_clamp;
                        if (w_clamp == '0) begin
                            r_gap   <= '0;
                            r_state <= c_GAP;
                        end else if (en_i) begin
                            r_state <= c_READ;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                c_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_gap   <= '0;
                        r_state <= en_i ? c_POLL : c_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                c_READ: begin
                    if (!r_wbd_stb) begin
                        r_wbd_stb <= 1'b1;
                    end else if (wbd_ack_i) begin
                        r_wbd_stb <= 1'b0;
                        r_data    <= wbd_dat_i;
                        r_valid   <= 1'b1;
                        r_rem     <= r_rem - 1'b1;
                        r_state   <= c_PUSH;
                    end
                end
                c_PUSH: begin
                    if (m_ready_i) begin
                        r_valid    <= 1'b0;
                        r_word_cnt <= r_word_cnt + 16'd1;
                        if (!en_i) begin
                            r_state <= c_IDLE;
                        end else if (r_rem != '0) begin
                            r_state <= c_READ;
                        end else begin
                            r_state <= c_POLL;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign wbs_cyc_o  = r_wbs_stb;
    assign wbs_stb_o  = r_wbs_stb;
    assign wbd_cyc_o  = r_wbd_stb;
    assign wbd_stb_o  = r_wbd_stb;
    assign m_valid_o  = r_valid;
    assign m_data_o   = r_data;
    assign busy_o     = (r_state != c_IDLE);
    assign word_cnt_o = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_fifo_drain_ctrl.sv
// ============================================================================
// Module   : tb_wb_fifo_drain_ctrl
// Brief    : Directed self-checking bench for wb_fifo_drain_ctrl with a
//            zero-wait FIFO slave model and stream/protocol monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_fifo_drain_ctrl;

    logic        clk       = 1'b0;
    logic        rst_i     = 1'b1;
    logic        en_i      = 1'b0;
    logic        m_ready_i = 1'b0;
    logic        wbs_cyc_o, wbs_stb_o, wbd_cyc_o, wbd_stb_o;
    logic        wbs_ack_i = 1'b0;
    logic        wbd_ack_i = 1'b0;
    logic [31:0] wbs_dat_i = 32'd0;
    logic [31:0] wbd_dat_i = 32'd0;
    logic        m_valid_o, busy_o, err_o;
    logic [31:0] m_data_o;
    logic [15:0] word_cnt_o;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          cyc      = 0;
    int          proto_err = 0;
    int          stb_valid_err = 0;
    logic        s_ack_en = 1'b1;
    logic        prev_d_ack = 1'b0;
    logic [31:0] fifo_q[$];
    logic [31:0] rx_q[$];
    int          rx_t[$];
    int          poll_q[$];
    int          poll_t[$];
    int          burst_q[$];

    always #5 clk = ~clk;

    wb_fifo_drain_ctrl #(.ADR_W(4), .BURST_MAX(8), .POLL_GAP(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
        .wbd_cyc_o(wbd_cyc_o), .wbd_stb_o(wbd_stb_o), .wbd_ack_i(wbd_ack_i), .wbd_dat_i(wbd_dat_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .busy_o(busy_o), .word_cnt_o(word_cnt_o), .err_o(err_o)
    );

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (wbd_stb_o && wbd_ack_i && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end

    // Slave responses and monitors, all on the falling edge.
    always @(negedge clk) begin
        wbs_ack_i = wbs_stb_o && s_ack_en;
        wbs_dat_i = 32'h5A5A_5A40 | 32'(fifo_q.size());
        wbd_ack_i = wbd_stb_o;
        wbd_dat_i = (fifo_q.size() > 0) ? fifo_q[0] : 32'hBAD0_BAD0;
        if (wbs_cyc_o !== wbs_stb_o || wbd_cyc_o !== wbd_stb_o || (wbs_cyc_o && wbd_cyc_o)) proto_err++;
        if (prev_d_ack && wbd_stb_o) proto_err++;
        if (wbd_stb_o && m_valid_o) stb_valid_err++;
        prev_d_ack = wbd_stb_o && wbd_ack_i;
        if (wbs_stb_o && wbs_ack_i) begin
            poll_q.push_back(fifo_q.size());
            poll_t.push_back(cyc);
            burst_q.push_back(0);
        end
        if (wbd_stb_o && wbd_ack_i && burst_q.size() > 0) burst_q[burst_q.size()-1] += 1;
        if (m_valid_o && m_ready_i) begin
            rx_q.push_back(m_data_o);
            rx_t.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en_i = 1'b0;
        m_ready_i = 1'b0;
        s_ack_en = 1'b1;
        rst_i = 1'b1;
        step();
        step();
        fifo_q.delete(); rx_q.delete(); rx_t.delete();
        poll_q.delete(); poll_t.delete(); burst_q.delete();
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        chk_cnt++; if ({wbs_cyc_o, wbs_stb_o, wbd_cyc_o, wbd_stb_o} !== 4'b0) $display("FAIL reset_wb: got %b expected 0000", {wbs_cyc_o, wbs_stb_o, wbd_cyc_o, wbd_stb_o}); else pass_cnt++;
        chk_cnt++; if (m_valid_o !== 1'b0 || m_data_o !== 32'd0) $display("FAIL reset_stream: got valid=%b data=%h expected 0/0", m_valid_o, m_data_o); else pass_cnt++;
        chk_cnt++; if (busy_o !== 1'b0 || err_o !== 1'b0) $display("FAIL reset_flags: got busy=%b err=%b expected 0/0", busy_o, err_o); else pass_cnt++;
        chk_cnt++; if (word_cnt_o !== 16'd0) $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt_o); else pass_cnt++;
        rst_i = 1'b0;
        step();
        step();
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_idle_no_en: got busy=%b expected 0", busy_o); else pass_cnt++;
    endtask

    task automatic test_burst5();
        int n;
        int errs;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hA0 + i);
        m_ready_i = 1'b1;
        en_i = 1'b1;
        n = 0; while (word_cnt_o != 16'd5 && n < 300) begin step(); n++; end
        n = 0; while (poll_q.size() < 3 && n < 100) begin step(); n++; end
        chk_cnt++; if (word_cnt_o !== 16'd5) $display("FAIL burst5_word_cnt: got %0d expected 5", word_cnt_o); else pass_cnt++;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            got = (rx_q.size() > i) ? rx_q[i] : 32'hFFFF_FFFF;
            if (got !== 32'hA0 + i) errs++;
        end
        chk_cnt++; if (rx_q.size() != 5 || errs != 0) $display("FAIL burst5_stream: got %0d words %0d wrong expected 5 words A0..A4", rx_q.size(), errs); else pass_cnt++;
        chk_cnt++; if (poll_q.size() < 2 || poll_q[0] != 5 || poll_q[1] != 0) $display("FAIL burst5_polls: got %0d polls first=%0d expected 5 then 0", poll_q.size(), (poll_q.size() > 0) ? poll_q[0] : -1); else pass_cnt++;
        chk_cnt++; if (burst_q.size() < 1 || burst_q[0] != 5) $display("FAIL burst5_burst_len: got %0d expected 5", (burst_q.size() > 0) ? burst_q[0] : -1); else pass_cnt++;
        chk_cnt++; if (rx_t.size() < 2 || rx_t[1] - rx_t[0] != 3) $display("FAIL burst5_word_spacing: got %0d expected 3", (rx_t.size() > 1) ? rx_t[1] - rx_t[0] : -1); else pass_cnt++;
        chk_cnt++; if (poll_t.size() < 3 || poll_t[2] - poll_t[1] != 6) $display("FAIL burst5_poll_spacing: got %0d expected 6", (poll_t.size() > 2) ? poll_t[2] - poll_t[1] : -1); else pass_cnt++;
        en_i = 1'b0;
        n = 0; while (busy_o && n < 50) begin step(); n++; end
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL burst5_to_idle: got busy=%b expected 0", busy_o); else pass_cnt++;
    endtask

    task automatic test_burst20();
        int n;
        int errs;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(32'hB00 + i);
        m_ready_i = 1'b1;
        en_i = 1'b1;
        n = 0; while (word_cnt_o != 16'd20 && n < 500) begin step(); n++; end
        n = 0; while (poll_q.size() < 4 && n < 100) begin step(); n++; end
        chk_cnt++; if (word_cnt_o !== 16'd20) $display("FAIL burst20_word_cnt: got %0d expected 20", word_cnt_o); else pass_cnt++;
        chk_cnt++; if (poll_q.size() < 4 || poll_q[0] != 20 || poll_q[1] != 12 || poll_q[2] != 4 || poll_q[3] != 0) $display("FAIL burst20_polls: got %0d polls expected counts 20,12,4,0", poll_q.size()); else pass_cnt++;
        chk_cnt++; if (burst_q.size() < 3 || burst_q[0] != 8 || burst_q[1] != 8 || burst_q[2] != 4) $display("FAIL burst20_bursts: got %0d bursts expected 8,8,4", burst_q.size()); else pass_cnt++;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            got = (rx_q.size() > i) ? rx_q[i] : 32'hFFFF_FFFF;
            if (got !== 32'hB00 + i) errs++;
        end
        chk_cnt++; if (rx_q.size() != 20 || errs != 0) $display("FAIL burst20_stream: got %0d words %0d wrong expected 20 in order", rx_q.size(), errs); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        int unstable;
        do_reset();
        stb_valid_err = 0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hC0 + i);
        m_ready_i = 1'b1;
        en_i = 1'b1;
        n = 0; while (rx_q.size() < 1 && n < 100) begin step(); n++; end
        m_ready_i = 1'b0;
        n = 0; while (!m_valid_o && n < 20) begin step(); n++; end
        chk_cnt++; if (m_valid_o !== 1'b1 || m_data_o !== 32'hC1) $display("FAIL bp_word: got valid=%b data=%h expected 1/000000c1", m_valid_o, m_data_o); else pass_cnt++;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_valid_o !== 1'b1 || m_data_o !== 32'hC1 || word_cnt_o !== 16'd1) unstable++;
        end
        chk_cnt++; if (unstable != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); else pass_cnt++;
        m_ready_i = 1'b1;
        n = 0; while (word_cnt_o != 16'd4 && n < 100) begin step(); n++; end
        chk_cnt++; if (rx_q.size() != 4 || rx_q[1] !== 32'hC1 || rx_q[3] !== 32'hC3) $display("FAIL bp_stream: got %0d words expected 4 (C0..C3)", rx_q.size()); else pass_cnt++;
        chk_cnt++; if (stb_valid_err != 0) $display("FAIL bp_stb_while_valid: got %0d expected 0", stb_valid_err); else pass_cnt++;
    endtask

    task automatic test_en_drop();
        int n;
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hD0 + i);
        m_ready_i = 1'b1;
        en_i = 1'b1;
        n = 0; while (rx_q.size() < 2 && n < 100) begin step(); n++; end
        n = 0; while (!wbd_stb_o && n < 10) begin step(); n++; end
        chk_cnt++; if (wbd_stb_o !== 1'b1) $display("FAIL endrop_strobe: got wbd_stb=%b expected 1", wbd_stb_o); else pass_cnt++;
        en_i = 1'b0;
        n = 0; while (busy_o && n < 20) begin step(); n++; end
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL endrop_idle: got busy=%b expected 0", busy_o); else pass_cnt++;
        chk_cnt++; if (rx_q.size() != 3 || rx_q[2] !== 32'hD2) $display("FAIL endrop_stream: got %0d words expected 3 ending D2", rx_q.size()); else pass_cnt++;
        chk_cnt++; if (fifo_q.size() != 2) $display("FAIL endrop_fifo_left: got %0d expected 2", fifo_q.size()); else pass_cnt++;
        chk_cnt++; if (word_cnt_o !== 16'd3) $display("FAIL endrop_word_cnt: got %0d expected 3", word_cnt_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'hE0 + i);
        m_ready_i = 1'b1;
        en_i = 1'b1;
        n = 0; while (rx_q.size() < 1 && n < 100) begin step(); n++; end
        m_ready_i = 1'b0;
        n = 0; while (!m_valid_o && n < 20) begin step(); n++; end
        chk_cnt++; if (m_valid_o !== 1'b1 || word_cnt_o !== 16'd1) $display("FAIL rstmid_pre: got valid=%b cnt=%0d expected 1/1", m_valid_o, word_cnt_o); else pass_cnt++;
        rst_i = 1'b1;
        #1;
        chk_cnt++; if (m_valid_o !== 1'b0 || m_data_o !== 32'd0) $display("FAIL rstmid_stream: got valid=%b data=%h expected 0/0", m_valid_o, m_data_o); else pass_cnt++;
        chk_cnt++; if (busy_o !== 1'b0 || word_cnt_o !== 16'd0) $display("FAIL rstmid_state: got busy=%b cnt=%0d expected 0/0", busy_o, word_cnt_o); else pass_cnt++;
        step();
        rst_i = 1'b0;
        en_i = 1'b0;
        step();
        step();
        chk_cnt++; if (word_cnt_o !== 16'd0 || busy_o !== 1'b0) $display("FAIL rstmid_after: got cnt=%0d busy=%b expected 0/0", word_cnt_o, busy_o); else pass_cnt++;
        chk_cnt++; if (rx_q.size() != 1) $display("FAIL rstmid_no_delivery: got %0d words expected 1", rx_q.size()); else pass_cnt++;
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        s_ack_en = 1'b0;
        en_i = 1'b1;
        n = 0; while (!wbs_stb_o && n < 10) begin step(); n++; end
        n = 0; while (wbs_stb_o && n < 400) begin n++; step(); end
`ifdef DRAIN_CTRL_WATCHDOG_EN
        chk_cnt++; if (n != 255) $display("FAIL wdog_stb_cycles: got %0d expected 255", n); else pass_cnt++;
        chk_cnt++; if (err_o !== 1'b1) $display("FAIL wdog_err: got %b expected 1", err_o); else pass_cnt++;
        for (int i = 0; i < 5; i++) step();
        chk_cnt++; if (err_o !== 1'b1 || wbs_stb_o !== 1'b1) $display("FAIL wdog_sticky_restart: got err=%b stb=%b expected 1/1", err_o, wbs_stb_o); else pass_cnt++;
`else
        chk_cnt++; if (n != 400 || wbs_stb_o !== 1'b1) $display("FAIL nowdog_stb_held: got %0d cycles stb=%b expected 400/1", n, wbs_stb_o); else pass_cnt++;
        chk_cnt++; if (err_o !== 1'b0) $display("FAIL nowdog_err: got %b expected 0", err_o); else pass_cnt++;
`endif
        do_reset();
    endtask

    task automatic test_protocol();
        chk_cnt++; if (proto_err != 0) $display("FAIL protocol: got %0d violations expected 0", proto_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_burst5();
        test_burst20();
        test_backpressure();
        test_en_drop();
        test_reset_mid();
        test_watchdog();
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_fifo_drain_ctrl.md
# wb_fifo_drain_ctrl

Wishbone master sequencer that empties the 32-bit test-bench FIFO through its read-side ports. It polls the read-status port for the current word count, issues a burst of single-word reads on the read-data port, and forwards each word on a valid/ready stream. It sits between the FIFO reader's Wishbone slaves and the bench's checker/scoreboard, so the bench never drives read transactions by hand.

## Interface
Parameters:
- ADR_W, 4, FIFO depth exponent; the status count field is ADR_W+1 bits.
- BURST_MAX, 8, maximum data reads per poll, in the range 1..2^ADR_W.
- POLL_GAP, 4, idle cycles between polls after a zero count, at least 1.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  run enable, level-sensitive.
- wbs_cyc_o  out  1  status-port cycle.
- wbs_stb_o  out  1  status-port strobe.
- wbs_ack_i  in  1  status-port acknowledge.
- wbs_dat_i  in  32  status word; bits [ADR_W:0] are the FIFO count, other bits are ignored.
- wbd_cyc_o  out  1  data-port cycle.
- wbd_stb_o  out  1  data-port strobe.
- wbd_ack_i  in  1  data-port acknowledge.
- wbd_dat_i  in  32  read data, valid while wbd_ack_i is high.
- m_valid_o  out  1  stream word valid.
- m_ready_i  in  1  stream sink ready.
- m_data_o  out  32  stream word.
- busy_o  out  1  high in any state other than IDLE.
- word_cnt_o  out  16  total words delivered; wraps from 0xFFFF to 0.
- err_o  out  1  sticky watchdog error; constant 0 unless the watchdog is compiled in.

## Operation
- Reset values: every output is 0, state is IDLE, and all internal counters are 0.
- Wishbone is classic single-cycle: cyc equals stb. Strobe is held until ack, and the controller never holds a cycle open on both ports at once.
- The FSM has five states: IDLE, POLL, GAP, READ and PUSH.
  - IDLE: if en_i is high, go to POLL.
  - POLL: assert wbs_cyc_o and wbs_stb_o. On wbs_ack_i, latch rem = min(count, BURST_MAX). If rem is 0, go to GAP; otherwise go to READ.
  - GAP: count POLL_GAP cycles, then go to POLL if en_i is high, or to IDLE if it is low.
  - READ: assert wbd_cyc_o and wbd_stb_o. On wbd_ack_i, register wbd_dat_i into m_data_o, set m_valid_o, decrement rem, and go to PUSH.
  - PUSH: hold m_valid_o and m_data_o stable until m_ready_i is high. On that transfer, clear m_valid_o and increment word_cnt_o. Then:
    - if rem is not 0 and en_i is high, go to READ;
    - if rem is 0 and en_i is high, go to POLL;
    - if en_i is low, go to IDLE.
- Dropping en_i never aborts an open Wishbone cycle or a pending stream word. The current transfer completes, then the FSM returns to IDLE.
- A count larger than 2^ADR_W is taken at face value, clamped only by BURST_MAX.
- Reset asserted mid-burst clears state immediately. An in-flight stream word is discarded and an in-flight Wishbone cycle is dropped.

## Timing
- Strobe asserts on the first clock edge after entry to POLL or READ.
- Ack is sampled on the clock edge. Strobe deasserts on the edge that samples ack, so it is never high in the cycle after ack.
- m_valid_o rises on the edge after the data-port ack. Minimum per-word latency from the data-port ack to the stream transfer is 1 cycle.
- With a zero-wait slave and an always-ready sink, one word takes 3 cycles: READ with ack, PUSH, then the next READ strobe.
- Poll-to-poll spacing on an empty FIFO is POLL_GAP + 1 cycles plus the slave ack latency.

## Configuration
- DRAIN_CTRL_WATCHDOG_EN defined:
  - An 8-bit counter runs while any strobe is high.
  - If 255 cycles pass without ack, the controller drops cyc and stb, sets err_o, clears rem and goes to IDLE.
  - err_o stays set until reset.
  - With en_i still high, operation restarts at POLL.
- DRAIN_CTRL_WATCHDOG_EN undefined: the controller waits indefinitely for ack, the counter is absent, and err_o is tied to 0.

## Test plan
- Prefill 5 words 0xA0..0xA4, set en_i high, keep m_ready_i high: one poll reads count 5, five data reads follow, the stream carries 0xA0..0xA4 in order, word_cnt_o ends at 5, then GAP/POLL repeats.
- Prefill 20 words with BURST_MAX = 8: polls read 20, then 12, then 4; bursts are 8, 8 and 4; word_cnt_o = 20 with no duplicate or missing word.
- Hold m_ready_i low for 10 cycles mid-burst: m_data_o stays stable, no wbd_stb_o is issued while m_valid_o is high, and the word is delivered once when ready rises.
- Deassert en_i during a READ strobe with 3 words remaining: the current ack completes, that word is pushed, the FSM returns to IDLE with busy_o = 0, and 2 words remain in the FIFO.
- Assert rst_i while m_valid_o = 1: all outputs read 0 in the same cycle and word_cnt_o = 0 after release.
- With the watchdog built in, the status slave never acks: wbs_stb_o drops after 255 cycles, err_o = 1 and stays set. Without the watchdog, wbs_stb_o stays high indefinitely.
